// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: receive side of the 2:1 bit-serial TDM link.
// Locks to frame sync, splits even/odd slots, and buffers word pairs.
module tdm_demux_rx #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         In_bit,
  input  logic         In_valid,
  input  logic         Sync,
  output logic [W-1:0] Out0,
  output logic [W-1:0] Out1,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic         Locked,
  output logic         Overflow
);

  localparam int SW = $clog2(2 * W);
  localparam logic [SW-1:0] LAST = SW'(2 * W - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  typedef enum logic {
    HUNT,
    RECV
  } st_t;

  st_t           st;
  st_t           st_nxt;
  logic [SW-1:0] slot;
  logic [SW-1:0] slot_nxt;
  logic [SW-1:0] wslot;
  logic [W-1:0]  sh0;
  logic [W-1:0]  sh1;
  logic [W-1:0]  sh0_nxt;
  logic [W-1:0]  sh1_nxt;
  logic          wr;
  logic          done;

  // Frame alignment FSM, slot counter and per-channel word assembly
  always_comb begin
    st_nxt   = st;
    slot_nxt = slot;
    sh0_nxt  = sh0;
    sh1_nxt  = sh1;
    wslot    = slot;
    wr       = 1'b0;
    done     = 1'b0;
    unique case (st)
      HUNT: begin
        if (In_valid && Sync) begin
          st_nxt   = RECV;
          wr       = 1'b1;
          wslot    = '0;
          sh0_nxt  = '0;
          sh1_nxt  = '0;
          slot_nxt = ONE;
        end
      end
      RECV: begin
        if (In_valid) begin
          wr = 1'b1;
          if (Sync) begin
            // realign: partial frame is thrown away
            wslot    = '0;
            sh0_nxt  = '0;
            sh1_nxt  = '0;
            slot_nxt = ONE;
          end else if (slot == LAST) begin
            done     = 1'b1;
            slot_nxt = '0;
          end else begin
            slot_nxt = slot + ONE;
          end
        end
      end
    endcase
    if (wr) begin
      if (wslot[0]) begin
        sh1_nxt[wslot[SW-1:1]] = In_bit;
      end else begin
        sh0_nxt[wslot[SW-1:1]] = In_bit;
      end
    end
  end

  // State, slot and shift register update
  always_ff @(posedge Clk) begin
    if (Rst) begin
      st   <= HUNT;
      slot <= '0;
      sh0  <= '0;
      sh1  <= '0;
    end else begin
      st   <= st_nxt;
      slot <= slot_nxt;
      sh0  <= sh0_nxt;
      sh1  <= sh1_nxt;
    end
  end

  // One-entry output buffer; a completion into a stalled full buffer is lost
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out0      <= '0;
      Out1      <= '0;
      Out_valid <= 1'b0;
      Overflow  <= 1'b0;
    end else if (done) begin
      if (!Out_valid || Out_ready) begin
        Out0      <= sh0_nxt;
        Out1      <= sh1_nxt;
        Out_valid <= 1'b1;
      end else begin
        Overflow <= 1'b1;
      end
    end else if (Out_valid && Out_ready) begin
      Out_valid <= 1'b0;
    end
  end

  assign Locked = (st == RECV);

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: scoreboard bench for the TDM receiver.
// Frame-level reference model feeds a queue popped on each handshake.
module tb_tdm_demux_rx;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_bit = 1'b0;
  logic         in_valid = 1'b0;
  logic         sync = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] out0;
  logic [W-1:0] out1;
  logic         out_valid;
  logic         locked;
  logic         overflow;

  int total = 0;
  int bad = 0;

  tdm_demux_rx #(.W(W)) dut (
    .Clk      (Clk),
    .Rst      (rst),
    .In_bit   (in_bit),
    .In_valid (in_valid),
    .Sync     (sync),
    .Out0     (out0),
    .Out1     (out1),
    .Out_valid(out_valid),
    .Out_ready(ready),
    .Locked   (locked),
    .Overflow (overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: frame position as an int, -1 while hunting
  logic [2*W-1:0] q[$];
  int             mslot = -1;
  logic [W-1:0]   c0 = '0;
  logic [W-1:0]   c1 = '0;
  logic           m_valid = 1'b0;
  logic           m_ovf = 1'b0;
  logic           m_locked = 1'b0;

  always @(posedge Clk) begin
    logic fin;
    logic hs;
    fin = 1'b0;
    if (rst) begin
      mslot = -1;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      q.delete();
    end else begin
      if (in_valid) begin
        if (sync) begin
          c0 = '0;
          c1 = '0;
          c0[0] = in_bit;
          mslot = 1;
        end else if (mslot >= 0) begin
          if (mslot % 2 == 0) c0[mslot/2] = in_bit;
          else c1[mslot/2] = in_bit;
          if (mslot == 2 * W - 1) begin
            fin = 1'b1;
            mslot = 0;
          end else begin
            mslot++;
          end
        end
      end
      hs = m_valid && ready;
      if (fin) begin
        if (!m_valid || hs) begin
          q.push_back({c0, c1});
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
    m_locked = (mslot >= 0);
  end

  // monitor: status every cycle, data on each accepted frame
  int           mon_cnt = 0;
  logic [W-1:0] mon0 = '0;
  logic [W-1:0] mon1 = '0;

  always @(negedge Clk) begin
    logic [2*W-1:0] e;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (out_valid && ready && !rst) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame: got=%0h/%0h want=none", out0, out1);
      end else begin
        e = q.pop_front();
        chk("out0", 32'(out0), 32'(e[2*W-1:W]));
        chk("out1", 32'(out1), 32'(e[W-1:0]));
        mon0 = out0;
        mon1 = out1;
        mon_cnt++;
      end
    end
  end

  logic rnd_ready = 1'b0;

  task automatic tick();
    if (rnd_ready) ready = ($urandom_range(0, 9) < 7);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    sync = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sync = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // gap: 0 none, 1 three idle clocks before slot 8, 2 random idles
  task automatic send(input logic [W-1:0] w0, input logic [W-1:0] w1,
                      input bit sf, input int gap, input int rl,
                      input int nslots);
    for (int k = 0; k < nslots; k++) begin
      int g;
      g = 0;
      if (gap == 1 && k == 8) g = 3;
      if (gap == 2 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_bit = 1'($urandom);
        sync = 1'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_bit = (k % 2 == 1) ? w1[k/2] : w0[k/2];
      sync = (k == 0) && sf;
      if (k == 2 * W - 1 && rl >= 0) ready = 1'(rl);
      tick();
    end
    in_valid = 1'b0;
    sync = 1'b0;
  endtask

  int base;

  initial begin
    do_reset();
    chk("rst_out0", 32'(out0), 0);
    chk("rst_out1", 32'(out1), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_locked", 32'(locked), 0);

    // basic frame
    ready = 1'b1;
    send(8'hA5, 8'h3C, 1, 0, -1, 16);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_out0", 32'(out0), 32'hA5);
    chk("t1_out1", 32'(out1), 32'h3C);
    chk("t1_locked", 32'(locked), 1);
    idle(1);
    chk("t1_pulse", 32'(out_valid), 0);

    // bits before sync are ignored
    do_reset();
    in_valid = 1'b1;
    sync = 1'b0;
    repeat (5) begin
      in_bit = 1'($urandom);
      tick();
    end
    chk("t2_hunt", 32'(locked), 0);
    send(8'hA5, 8'h3C, 1, 0, -1, 16);
    chk("t2_out0", 32'(out0), 32'hA5);
    chk("t2_out1", 32'(out1), 32'h3C);
    idle(2);

    // back-to-back, second frame without sync, mid-frame gaps
    base = mon_cnt;
    send(8'h01, 8'h80, 1, 1, -1, 16);
    send(8'hFF, 8'h00, 0, 1, -1, 16);
    idle(2);
    chk("t3_count", 32'(mon_cnt - base), 2);
    chk("t3_last0", 32'(mon0), 32'hFF);
    chk("t3_last1", 32'(mon1), 32'h00);

    // stalled consumer: second frame dropped
    do_reset();
    ready = 1'b0;
    send(8'h11, 8'h22, 1, 0, -1, 16);
    send(8'h33, 8'h44, 0, 0, -1, 16);
    idle(1);
    chk("t4_hold0", 32'(out0), 32'h11);
    chk("t4_hold1", 32'(out1), 32'h22);
    chk("t4_ovf", 32'(overflow), 1);
    // ready arrives on the completion cycle: swap, no drop
    do_reset();
    ready = 1'b0;
    send(8'h11, 8'h22, 1, 0, -1, 16);
    send(8'h33, 8'h44, 0, 0, 1, 16);
    chk("t4_swap0", 32'(out0), 32'h33);
    chk("t4_swap1", 32'(out1), 32'h44);
    chk("t4_noovf", 32'(overflow), 0);
    idle(2);

    // realign at slot 6
    base = mon_cnt;
    send(8'hFF, 8'hFF, 1, 0, -1, 6);
    send(8'h5A, 8'hC3, 1, 0, -1, 16);
    idle(2);
    chk("t5_count", 32'(mon_cnt - base), 1);
    chk("t5_out0", 32'(mon0), 32'h5A);
    chk("t5_out1", 32'(mon1), 32'hC3);

    // reset mid-frame and with a buffered frame
    send(8'h77, 8'h66, 1, 0, -1, 9);
    do_reset();
    chk("t6a_locked", 32'(locked), 0);
    chk("t6a_valid", 32'(out_valid), 0);
    ready = 1'b0;
    send(8'h9C, 8'h3E, 1, 0, -1, 16);
    chk("t6_buffered", 32'(out_valid), 1);
    do_reset();
    chk("t6b_out0", 32'(out0), 0);
    chk("t6b_out1", 32'(out1), 0);
    chk("t6b_valid", 32'(out_valid), 0);
    chk("t6b_locked", 32'(locked), 0);
    chk("t6b_ovf", 32'(overflow), 0);
    ready = 1'b1;
    send(8'hE1, 8'h1E, 1, 0, -1, 16);
    chk("t6c_out0", 32'(out0), 32'hE1);
    chk("t6c_out1", 32'(out1), 32'h1E);
    idle(2);

    // randomized traffic with random backpressure
    do_reset();
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0)
        send(8'($urandom), 8'($urandom), 1, 2, -1, $urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b1;
        sync = 1'b0;
        in_bit = 1'($urandom);
        tick();
      end
      send(8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1), 2, -1, 16);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    rnd_ready = 1'b0;
    ready = 1'b1;
    idle(4);
    chk("drain", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
